seg7_display_mux: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes the COUNT values of cascaded generic counters, packed as four hex/BCD nibbles, and scans one digit per refresh slot from its own refresh prescaler. Each frame is latched atomically, so a count that changes mid-scan is never shown half-updated. Optional leading-zero blanking is provided. It sits between the counter chain and the board's anode/cathode pins.

---
 rtl/seg7_display_mux.sv | 122 ++++++++++++
 tb/tb_seg7_display_mux.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg7_display_mux.sv
// Four-digit common-anode seven-segment scanner. Each frame's digits and dots are
// snapshotted at the frame boundary, and leading zeros can optionally be blanked.
module seg7_display_mux #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned DIV_WIDTH     = 17,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] DIGITS,
  input  logic [3:0]  DOTS,
  output logic [3:0]  SEG_SELECT_OUT,
  output logic [7:0]  HEX_OUT,
  output logic        FRAME_TICK
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

  logic [DIV_WIDTH-1:0] r_div;
  logic [1:0]           r_slot;
  logic [15:0]          r_shadow_digits;
  logic [3:0]           r_shadow_dots;

  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [1:0]           w_slot_nxt;
  logic [15:0]          w_shadow_digits_nxt;
  logic [3:0]           w_shadow_dots_nxt;
  logic                 w_frame_nxt;
  logic [3:0]           w_sel_nxt;
  logic [7:0]           w_hex_nxt;
  logic                 w_slot_tick;
  logic [3:0]           w_nibble;
  logic [6:0]           w_seg7;
  logic                 w_blank;

  assign w_slot_tick = ENABLE && (r_div == DIV_LAST);
  assign w_nibble    = r_shadow_digits[{r_slot, 2'b00} +: 4];

  // Active-low segment patterns, bit0 = a .. bit6 = g
  always_comb begin
    w_seg7 = 7'h7F;
    case (w_nibble)
      4'h0: w_seg7 = 7'h40;
      4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;
      4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;
      4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;
      4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;
      4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = 7'h08;
      4'hB: w_seg7 = 7'h03;
      4'hC: w_seg7 = 7'h46;
      4'hD: w_seg7 = 7'h21;
      4'hE: w_seg7 = 7'h06;
      4'hF: w_seg7 = 7'h0E;
      default: w_seg7 = 7'h7F;
    endcase
  end

  // A digit is a leading zero when it and every more significant nibble are zero
  always_comb begin
    w_blank = 1'b0;
    case (r_slot)
      2'd1: w_blank = (r_shadow_digits[15:4] == 12'h000);
      2'd2: w_blank = (r_shadow_digits[15:8] == 8'h00);
      2'd3: w_blank = (r_shadow_digits[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank && BLANK_LEADING;
  end

  // Next-state for prescaler, slot, snapshot and pin registers
  always_comb begin
    w_div_nxt           = r_div;
    w_slot_nxt          = r_slot;
    w_shadow_digits_nxt = r_shadow_digits;
    w_shadow_dots_nxt   = r_shadow_dots;
    w_frame_nxt         = 1'b0;
    w_sel_nxt           = 4'hF;
    w_hex_nxt           = 8'hFF;
    if (ENABLE) begin
      w_sel_nxt = ~(4'b0001 << r_slot);
      w_hex_nxt = {~r_shadow_dots[r_slot], (w_blank ? 7'h7F : w_seg7)};
      if (w_slot_tick) begin
        w_div_nxt  = '0;
        w_slot_nxt = r_slot + 2'd1;
        if (r_slot == 2'd3) begin
          w_shadow_digits_nxt = DIGITS;
          w_shadow_dots_nxt   = DOTS;
          w_frame_nxt         = 1'b1;
        end
      end else begin
        w_div_nxt = r_div + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div           <= '0;
      r_slot          <= 2'd0;
      r_shadow_digits <= 16'h0000;
      r_shadow_dots   <= 4'h0;
      SEG_SELECT_OUT  <= 4'hF;
      HEX_OUT         <= 8'hFF;
      FRAME_TICK      <= 1'b0;
    end else begin
      r_div           <= w_div_nxt;
      r_slot          <= w_slot_nxt;
      r_shadow_digits <= w_shadow_digits_nxt;
      r_shadow_dots   <= w_shadow_dots_nxt;
      SEG_SELECT_OUT  <= w_sel_nxt;
      HEX_OUT         <= w_hex_nxt;
      FRAME_TICK      <= w_frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_display_mux.sv
// Scoreboard bench for seg7_display_mux (REFRESH_DIV = 4): the stimulus pushes hand-computed
// pin values per edge, and a monitor pops them and compares against one of two DUT instances.
module tb_seg7_display_mux;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] DIGITS;
  logic [3:0]  DOTS;
  logic [3:0]  seg_b, seg_n;
  logic [7:0]  hex_b, hex_n;
  logic        ft_b, ft_n;

  typedef struct {
    logic       which;
    logic [3:0] seg;
    logic [7:0] hex;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  seg7_display_mux #(.REFRESH_DIV(4), .DIV_WIDTH(3), .BLANK_LEADING(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIGITS(DIGITS), .DOTS(DOTS),
    .SEG_SELECT_OUT(seg_b), .HEX_OUT(hex_b), .FRAME_TICK(ft_b));

  seg7_display_mux #(.REFRESH_DIV(4), .DIV_WIDTH(3), .BLANK_LEADING(1'b0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIGITS(DIGITS), .DOTS(DOTS),
    .SEG_SELECT_OUT(seg_n), .HEX_OUT(hex_n), .FRAME_TICK(ft_n));

  // Monitor: outputs are presented every edge; check each one that has an expectation
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [3:0] s;
      logic [7:0] h;
      logic       f;
      e = q.pop_front();
      s = e.which ? seg_n : seg_b;
      h = e.which ? hex_n : hex_b;
      f = e.which ? ft_n  : ft_b;
      n_checks++;
      if (s === e.seg && h === e.hex && f === e.ft) n_pass++;
      else $display("FAIL pins[%0d] t=%0t dut%0d: got sel=%h hex=%h ft=%b, want sel=%h hex=%h ft=%b",
                    n_checks, $time, e.which, s, h, f, e.seg, e.hex, e.ft);
    end
  end

  // Expect (seg,hex,ft) for the next n edges; inputs set before the call apply to those edges
  task automatic run(input int n, input logic [3:0] seg, input logic [7:0] hex,
                     input logic ft, input logic which = 1'b0);
    exp_t e;
    e.which = which; e.seg = seg; e.hex = hex; e.ft = ft;
    for (int i = 0; i < n; i++) begin
      q.push_back(e);
      @(negedge CLK);
    end
  endtask

  task automatic frame(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] h2,
                       input logic [7:0] h3, input logic which = 1'b0);
    run(4, 4'hE, h0, 1'b0, which);
    run(4, 4'hD, h1, 1'b0, which);
    run(4, 4'hB, h2, 1'b0, which);
    run(3, 4'h7, h3, 1'b0, which);
    run(1, 4'h7, h3, 1'b1, which);
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; DIGITS = 16'h1234; DOTS = 4'h0;
    run(2, 4'hF, 8'hFF, 1'b0);
    RESET = 1'b0; ENABLE = 1'b1;
    frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);            // zeroed shadow after reset
    frame(8'h99, 8'hB0, 8'hA4, 8'hF9);            // 1234
    // 0050 arrives on the snapshot edge itself and must be captured
    run(4, 4'hE, 8'h99, 1'b0);
    run(4, 4'hD, 8'hB0, 1'b0);
    run(4, 4'hB, 8'hA4, 1'b0);
    run(3, 4'h7, 8'hF9, 1'b0);
    DIGITS = 16'h0050;
    run(1, 4'h7, 8'hF9, 1'b1);
    DIGITS = 16'h0000; DOTS = 4'b0100;
    frame(8'hC0, 8'h92, 8'hFF, 8'hFF);            // 0050
    DOTS = 4'h0;
    frame(8'hC0, 8'hFF, 8'h7F, 8'hFF);            // 0000, dot on blanked digit 2
    DIGITS = 16'h1234;
    frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b1);      // no-blanking instance shows 0000
    // Input change mid-frame stays invisible until the next snapshot
    run(4, 4'hE, 8'h99, 1'b0);
    DIGITS = 16'h5678;
    run(4, 4'hD, 8'hB0, 1'b0);
    run(4, 4'hB, 8'hA4, 1'b0);
    run(3, 4'h7, 8'hF9, 1'b0);
    run(1, 4'h7, 8'hF9, 1'b1);
    // Pause two cycles into slot 2, then resume with the remaining count
    run(4, 4'hE, 8'h80, 1'b0);
    run(4, 4'hD, 8'hF8, 1'b0);
    run(2, 4'hB, 8'h82, 1'b0);
    ENABLE = 1'b0;
    run(10, 4'hF, 8'hFF, 1'b0);
    ENABLE = 1'b1;
    run(2, 4'hB, 8'h82, 1'b0);
    run(3, 4'h7, 8'h92, 1'b0);
    run(1, 4'h7, 8'h92, 1'b1);
    // Reset in the middle of slot 3 clears the shadow and restarts the scan
    run(4, 4'hE, 8'h80, 1'b0);
    run(4, 4'hD, 8'hF8, 1'b0);
    run(4, 4'hB, 8'h82, 1'b0);
    run(2, 4'h7, 8'h92, 1'b0);
    RESET = 1'b1;
    run(1, 4'hF, 8'hFF, 1'b0);
    RESET = 1'b0; DIGITS = 16'h9ABC;
    frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    DIGITS = 16'hDEF0; DOTS = 4'hF;
    frame(8'hC6, 8'h83, 8'h88, 8'h90);            // 9ABC
    frame(8'h40, 8'h0E, 8'h06, 8'h21);            // DEF0, all dots lit
    @(posedge CLK);
    #3;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
